// File: rtl/decode_scan_ctrl.sv
// Scan controller that steps a 4-to-16 decoder select through codes 0..15.
// Optional macro SCAN_BLANK_EN inserts a one-cycle en=0 gap on every code step.
module decode_scan_ctrl #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [DWELL_W-1:0] dwell,
   output logic [3:0]         x,
   output logic               en,
   output logic               busy,
   output logic               done,
   output logic               wrap
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_t;

   localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

   state_t             state, state_nx;
   logic [3:0]         x_nx;
   logic               en_nx, busy_nx, done_nx, wrap_nx;
   logic [DWELL_W-1:0] cnt, cnt_nx;
   logic [DWELL_W-1:0] dwell_q, dwell_q_nx;
   logic               mode_q, mode_q_nx;
`ifdef SCAN_BLANK_EN
   // A wrap seen on the SHOW->BLANK step is reported when SHOW resumes.
   logic               wrap_pend, wrap_pend_nx;
`endif

   always_comb begin
      state_nx   = state;
      x_nx       = x;
      en_nx      = en;
      busy_nx    = busy;
      done_nx    = 1'b0;
      wrap_nx    = 1'b0;
      cnt_nx     = cnt;
      dwell_q_nx = dwell_q;
      mode_q_nx  = mode_q;
`ifdef SCAN_BLANK_EN
      wrap_pend_nx = 1'b0;
`endif
      case (state)
         IDLE: begin
            x_nx    = 4'd0;
            en_nx   = 1'b0;
            busy_nx = 1'b0;
            if (start && !stop) begin
               state_nx   = SHOW;
               en_nx      = 1'b1;
               busy_nx    = 1'b1;
               cnt_nx     = dwell;
               dwell_q_nx = dwell;
               mode_q_nx  = mode;
            end
         end
         SHOW: begin
            if (stop) begin
               state_nx = IDLE;
               x_nx     = 4'd0;
               en_nx    = 1'b0;
               busy_nx  = 1'b0;
               cnt_nx   = '0;
            end else if (cnt != '0) begin
               cnt_nx = cnt - CNT_ONE;
            end else if (x != 4'hF || mode_q) begin
               // x wraps 15 -> 0 naturally in continuous mode.
               x_nx   = x + 4'd1;
               cnt_nx = dwell_q;
`ifdef SCAN_BLANK_EN
               state_nx     = BLANK;
               en_nx        = 1'b0;
               wrap_pend_nx = (x == 4'hF);
`else
               wrap_nx = (x == 4'hF);
`endif
            end else begin
               state_nx = IDLE;
               x_nx     = 4'd0;
               en_nx    = 1'b0;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end
         end
         BLANK: begin
            if (stop) begin
               state_nx = IDLE;
               x_nx     = 4'd0;
               en_nx    = 1'b0;
               busy_nx  = 1'b0;
               cnt_nx   = '0;
            end else begin
               state_nx = SHOW;
               en_nx    = 1'b1;
`ifdef SCAN_BLANK_EN
               wrap_nx  = wrap_pend;
`endif
            end
         end
         default: begin
            state_nx = IDLE;
            x_nx     = 4'd0;
            en_nx    = 1'b0;
            busy_nx  = 1'b0;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         x       <= 4'd0;
         en      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wrap    <= 1'b0;
         cnt     <= '0;
         dwell_q <= '0;
         mode_q  <= 1'b0;
`ifdef SCAN_BLANK_EN
         wrap_pend <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         x       <= x_nx;
         en      <= en_nx;
         busy    <= busy_nx;
         done    <= done_nx;
         wrap    <= wrap_nx;
         cnt     <= cnt_nx;
         dwell_q <= dwell_q_nx;
         mode_q  <= mode_q_nx;
`ifdef SCAN_BLANK_EN
         wrap_pend <= wrap_pend_nx;
`endif
      end
   end

endmodule

// File: tb/tb_decode_scan_ctrl.sv
// Scoreboard bench for decode_scan_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_decode_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] dwell = 8'd0;
   logic [3:0] x;
   logic       en, busy, done, wrap;

`ifdef SCAN_BLANK_EN
   localparam bit BLANK_GAP = 1'b1;
`else
   localparam bit BLANK_GAP = 1'b0;
`endif

   typedef struct {
      logic [7:0] v;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   decode_scan_ctrl #(.DWELL_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .stop  (stop),
      .mode  (mode),
      .dwell (dwell),
      .x     (x),
      .en    (en),
      .busy  (busy),
      .done  (done),
      .wrap  (wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pk(input logic [3:0] xx, input logic e, input logic b,
                                     input logic d, input logic w);
      return {xx, e, b, d, w};
   endfunction

   // Drive inputs for the next edge, then queue the outputs expected after it.
   task automatic cyc(input logic st, input logic sp, input logic r, input logic [7:0] ev,
                      input int id);
      exp_t e;
      start = st;
      stop  = sp;
      rst   = r;
      @(posedge clk);
      #1;
      e.v  = ev;
      e.id = id;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_cmp++;
         if ({x, en, busy, done, wrap} !== mon_e.v) begin
            n_bad++;
            $display("FAIL test%0d outputs at %0t: got x=%0d en=%0b busy=%0b done=%0b wrap=%0b, want x=%0d en=%0b busy=%0b done=%0b wrap=%0b",
                     mon_e.id, $time, x, en, busy, done, wrap, mon_e.v[7:4], mon_e.v[3],
                     mon_e.v[2], mon_e.v[1], mon_e.v[0]);
         end
      end
   end

   // abort_kind: 0 none, 1 stop (with start) when code abort_code first shows,
   // 2 rst (with start) at the same point. noise: stray start and dwell/mode edits mid-sweep.
   task automatic sweep(input int id, input int dw, input bit md, input int total,
                        input int abort_kind, input int abort_code, input bit noise);
      int         idx;
      logic       st;
      logic [3:0] c;
      idx   = 0;
      dwell = dw[7:0];
      mode  = md;
      for (int k = 0; k < total; k++) begin
         c = 4'(k % 16);
         if (k > 0 && BLANK_GAP) begin
            cyc(1'b0, 1'b0, 1'b0, pk(c, 1'b0, 1'b1, 1'b0, 1'b0), id);
            idx++;
         end
         for (int h = 0; h <= dw; h++) begin
            st = (idx == 0) || (noise && (idx == 5 || idx == 9));
            cyc(st, 1'b0, 1'b0, pk(c, 1'b1, 1'b1, 1'b0, (k > 0 && c == 4'd0 && h == 0)), id);
            if (noise && idx == 2) begin
               dwell = 8'd0;
               mode  = ~md;
            end
            idx++;
            if (abort_kind != 0 && k == abort_code && h == 0) begin
               cyc(1'b1, abort_kind == 1, abort_kind == 2, pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0), id);
               cyc(1'b0, 1'b0, 1'b0, pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0), id);
               return;
            end
         end
      end
      if (!md) begin
         cyc(1'b0, 1'b0, 1'b0, pk(4'd0, 1'b0, 1'b0, 1'b1, 1'b0), id);
      end else begin
         cyc(1'b0, 1'b1, 1'b0, pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0), id);
      end
      cyc(1'b0, 1'b0, 1'b0, pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0), id);
   endtask

   initial begin
      // Reset state, including rst overriding a simultaneous start.
      cyc(1'b0, 1'b0, 1'b1, pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1);
      cyc(1'b1, 1'b0, 1'b1, pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1);
      cyc(1'b0, 1'b0, 1'b0, pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1);
      sweep(2, 0, 1'b0, 16, 0, 0, 1'b0);
      sweep(3, 3, 1'b0, 16, 0, 0, 1'b0);
      sweep(4, 1, 1'b1, 48, 0, 0, 1'b0);
      sweep(5, 2, 1'b0, 16, 1, 7, 1'b0);
      // start and stop together in IDLE must stay idle.
      cyc(1'b1, 1'b1, 1'b0, pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0), 6);
      cyc(1'b0, 1'b0, 1'b0, pk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0), 6);
      sweep(7, 0, 1'b0, 16, 2, 9, 1'b0);
      sweep(8, 2, 1'b0, 16, 0, 0, 1'b1);
      sweep(9, 0, 1'b1, 20, 1, 3, 1'b0);
      start = 1'b0;
      stop  = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish, got %0d compared", n_cmp);
      $fatal(1, "timeout");
   end

endmodule
